// File: rtl/snake_pkg.sv
// Constants shared by the snake game controller and snake_field: direction codes,
// cell codes, sequencer state encoding and the direction-pick helpers.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [2:0] CELL_EMPTY = 3'd0;
    localparam logic [2:0] CELL_APPLE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_STEP,
        ST_SETTLE,
        ST_OVER
    } state_e;

    // Lowest set button index wins when several are pressed together.
    function automatic logic [1:0] dir_pick(input logic [3:0] btn);
        if (btn[0])      return DIR_UP;
        else if (btn[1]) return DIR_RIGHT;
        else if (btn[2]) return DIR_DOWN;
        else             return DIR_LEFT;
    endfunction

    // Opposite directions differ only in bit 1, so XOR == 2 means a reversal.
    function automatic logic dir_legal(input logic [1:0] cand, input logic [1:0] cur);
        return (cand ^ cur) != 2'd2;
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 16-bit maximal-length Galois LFSR (taps 16,14,13,11), free-running while enabled.
// Exposes only the low OUT_W bits that the caller consumes.
module snake_lfsr #(
    parameter int          OUT_W = 7,
    parameter logic [15:0] SEED  = 16'h0001
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [OUT_W-1:0] q_o
);
    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ TAPS) : {1'b0, lfsr_q[15:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: start/step pulse timing, reversal-proof direction filter,
// apple seed and saturating score; the step period shrinks as apples are eaten.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int SIZE_X      = 10,
    parameter int SIZE_Y      = 10,
    parameter int TICK_PERIOD = 25_000_000,
    parameter int TICK_MIN    = 5_000_000,
    parameter int TICK_DEC    = 1_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 btn_start,
    input  logic [3:0]                           btn_dir,
    input  logic                                 field_alive,
    input  logic                                 apple_eaten,
    output logic                                 start,
    output logic                                 step,
    output logic [1:0]                           snake_dir,
    output logic [$clog2(SIZE_X*SIZE_Y)-1:0]     seed,
    output logic [SCORE_W-1:0]                   score,
    output logic                                 game_over
);
    localparam int N_CELLS = SIZE_X * SIZE_Y;
    localparam int SEED_W  = $clog2(N_CELLS);
    localparam int PER_W   = $clog2(TICK_PERIOD + 1);

    localparam logic [PER_W-1:0]  PER_INIT = PER_W'(TICK_PERIOD);
    localparam logic [PER_W-1:0]  PER_MIN  = PER_W'(TICK_MIN);
    localparam logic [PER_W-1:0]  PER_DEC  = PER_W'(TICK_DEC);
    localparam logic [SEED_W:0]   N_EXT    = (SEED_W + 1)'(N_CELLS);

    state_e              state_q;
    logic [PER_W-1:0]    period_q, period_d;
    logic [PER_W-1:0]    cnt_q;
    logic [1:0]          cur_dir_q, snake_dir_q;
    logic [1:0]          dir_cand;
    logic                dir_acc;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                start_q, step_q, over_q;
    logic [SEED_W-1:0]   rnd;
    logic [SEED_W-1:0]   seed_q, seed_d;

    snake_lfsr #(
        .OUT_W (SEED_W),
        .SEED  (16'h0001)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (1'b1),
        .q_o    (rnd)
    );

    always_comb begin
        dir_cand = dir_pick(btn_dir);
        dir_acc  = (|btn_dir) && dir_legal(dir_cand, cur_dir_q)
                   && (state_q == ST_RUN || state_q == ST_SETTLE);
        // Underflow is caught before the floor clamp so a small period never wraps.
        if (period_q < PER_DEC || (period_q - PER_DEC) < PER_MIN) begin
            period_d = PER_MIN;
        end else begin
            period_d = period_q - PER_DEC;
        end
        score_d = (&score_q) ? score_q : score_q + 1'b1;
        // rnd < 2^SEED_W < 2*N_CELLS, so one conditional subtraction lands below N_CELLS.
        seed_d  = ({1'b0, rnd} >= N_EXT) ? SEED_W'({1'b0, rnd} - N_EXT) : rnd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= '0;
        end else begin
            seed_q <= seed_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            step_q      <= 1'b0;
            over_q      <= 1'b0;
            score_q     <= '0;
            snake_dir_q <= DIR_RIGHT;
            cur_dir_q   <= DIR_RIGHT;
            period_q    <= PER_INIT;
            cnt_q       <= '0;
        end else begin
            start_q <= 1'b0;
            step_q  <= 1'b0;
            if (dir_acc) begin
                snake_dir_q <= dir_cand;
            end
            case (state_q)
                ST_IDLE: begin
                    if (btn_start) begin
                        state_q <= ST_INIT;
                        start_q <= 1'b1;
                    end
                end
                ST_INIT: begin
                    score_q     <= '0;
                    period_q    <= PER_INIT;
                    cnt_q       <= PER_INIT - 1'b1;
                    cur_dir_q   <= DIR_RIGHT;
                    snake_dir_q <= DIR_RIGHT;
                    state_q     <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STEP: begin
                    cur_dir_q <= snake_dir_q;
                    state_q   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!field_alive) begin
                        state_q <= ST_OVER;
                        over_q  <= 1'b1;
                    end else begin
                        if (apple_eaten) begin
                            score_q  <= score_d;
                            period_q <= period_d;
                            cnt_q    <= period_d - 1'b1;
                        end else begin
                            cnt_q <= period_q - 1'b1;
                        end
                        state_q <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (btn_start) begin
                        state_q <= ST_INIT;
                        start_q <= 1'b1;
                        over_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign start     = start_q;
    assign step      = step_q;
    assign snake_dir = snake_dir_q;
    assign seed      = seed_q;
    assign score     = score_q;
    assign game_over = over_q;

endmodule
